// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA scan-out of a 320x240 RGB444 frame buffer with 2x2 pixel replication.
// Sync and colour leave through a matched three-register path that covers the buffer read latency.
module vga_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_WIDTH = 320,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [11:0]       rd_data,
    output logic              hsync,
    output logic              vsync,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0]    H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]    H_VIS    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]    HS_FIRST = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]    HS_LAST  = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0]    V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]    V_VIS    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0]    VS_FIRST = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]    VS_LAST  = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [ADDR_W-1:0] FB_STEP  = ADDR_W'(FB_WIDTH);

    logic [H_W-1:0]    h_cnt_q, h_cnt_d;
    logic [V_W-1:0]    v_cnt_q, v_cnt_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_en_q, rd_en_d;
    logic              active_d1_q, active_d1_d;
    logic              hs_d1_q, hs_d1_d;
    logic              vs_d1_q, vs_d1_d;
    logic              active_d2_q, active_d2_d;
    logic              hs_d2_q, hs_d2_d;
    logic              vs_d2_q, vs_d2_d;
    logic [11:0]       rgb_q, rgb_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              frame_end_q, frame_end_d;

    logic              h_wrap;
    logic              v_wrap;
    logic              active;
    logic              hs_raw;
    logic              vs_raw;
    logic [ADDR_W-1:0] pix_addr;

    always_comb begin
        h_wrap = (h_cnt_q == H_LAST);
        v_wrap = (v_cnt_q == V_LAST);
        active = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        hs_raw = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        vs_raw = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
        // Column halving gives horizontal replication; line_base only steps after odd lines.
        pix_addr = line_base_q + ADDR_W'(h_cnt_q[H_W-1:1]);
    end

    always_comb begin
        h_cnt_d     = h_wrap ? '0 : h_cnt_q + H_W'(1);
        v_cnt_d     = v_cnt_q;
        line_base_d = line_base_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + V_W'(1);
            if (v_wrap) begin
                line_base_d = '0;
            end else if ((v_cnt_q < V_VIS) && v_cnt_q[0]) begin
                line_base_d = line_base_q + FB_STEP;
            end
        end
        frame_end_d = h_wrap && v_wrap;
    end

    always_comb begin
        rd_addr_d   = active ? pix_addr : '0;
        rd_en_d     = active;
        active_d1_d = active;
        hs_d1_d     = hs_raw;
        vs_d1_d     = vs_raw;
        active_d2_d = active_d1_q;
        hs_d2_d     = hs_d1_q;
        vs_d2_d     = vs_d1_q;
        // rd_data now belongs to the address issued one clock earlier, matching the d2 stage.
        rgb_d       = active_d2_q ? rd_data : 12'h000;
        hsync_d     = hs_d2_q;
        vsync_d     = vs_d2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            line_base_q <= '0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            active_d1_q <= 1'b0;
            hs_d1_q     <= 1'b1;
            vs_d1_q     <= 1'b1;
            active_d2_q <= 1'b0;
            hs_d2_q     <= 1'b1;
            vs_d2_q     <= 1'b1;
            rgb_q       <= 12'h000;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            frame_end_q <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            line_base_q <= line_base_d;
            rd_addr_q   <= rd_addr_d;
            rd_en_q     <= rd_en_d;
            active_d1_q <= active_d1_d;
            hs_d1_q     <= hs_d1_d;
            vs_d1_q     <= vs_d1_d;
            active_d2_q <= active_d2_d;
            hs_d2_q     <= hs_d2_d;
            vs_d2_q     <= vs_d2_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign rd_en     = rd_en_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign vga_r     = rgb_q[11:8];
    assign vga_g     = rgb_q[7:4];
    assign vga_b     = rgb_q[3:0];
    assign frame_end = frame_end_q;

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Display-side stage that drains the 320x240 RGB444 frame buffer written by the camera pixel capture stage. Generates 640x480@60 Hz VGA timing from a 25 MHz pixel clock, reads the buffer's read port with 2x2 pixel replication, and drives sync and colour pins with the sync signals aligned to the buffer's one-cycle read latency. Reads and writes are asynchronous to each other. Frame tearing is accepted; no frame handshaking with the writer.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- FB_WIDTH, 320, buffer pixels per row; must equal H_ACTIVE/2
- ADDR_W, 17, buffer address width

Ports:
- clk  in  1  25 MHz pixel clock, the only clock in the block
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  out  ADDR_W  buffer read address
- rd_en  out  1  buffer read enable
- rd_data  in  12  buffer read data {R,G,B}, valid one clock after rd_addr/rd_en
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- vga_r, vga_g, vga_b  out  4 each  colour outputs
- frame_end  out  1  one-clock pulse per frame

## Operation
- h_cnt counts 0..799 (H_TOTAL = sum of H_*). It wraps to 0 after 799.
- v_cnt counts 0..524. It increments when h_cnt wraps, and wraps to 0 after 524.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Raw hsync is low for h_cnt in [656, 751]. Raw vsync is low for v_cnt in [490, 491].
- Address generation uses no multiplier:
  - line_base is a 17-bit register.
  - At h_cnt == 799: if v_cnt == 524, line_base <= 0. Otherwise, if v_cnt < V_ACTIVE and v_cnt[0] == 1, line_base <= line_base + FB_WIDTH. Otherwise line_base holds.
  - Combinational address = line_base + h_cnt[9:1]. The maximum value is 239*320 + 319 = 76799, so it fits in 17 bits with no overflow.
- Pipeline:
  - Stage 1 (registered): rd_addr <= active ? address : 0; rd_en <= active; active_d1, hs_d1, vs_d1 <= raw values.
  - Stage 2: active_d2, hs_d2, vs_d2 <= the stage 1 values. The buffer presents rd_data for the stage 1 address.
  - Output registers: {vga_r, vga_g, vga_b} <= active_d2 ? rd_data : 12'h000; hsync <= hs_d2; vsync <= vs_d2.
- frame_end is registered high for one clock when (h_cnt, v_cnt) == (799, 524). It is not delayed through the pipeline.
- No state machine beyond the counters. The buffer content is consumed as-is; pixel values are never checked.

## Timing
- Reset values (immediately on rst_n low, no clock required):
  - h_cnt = 0, v_cnt = 0, line_base = 0
  - rd_addr = 0, rd_en = 0
  - pipeline registers cleared; the sync stages reset to 1
  - hsync = 1, vsync = 1, vga_r/g/b = 0, frame_end = 0
- Cycle 0 is the first rising edge after rst_n deasserts; counters hold (0,0) until then.
- rd_addr/rd_en reflect the counter position after 1 clock.
- Colour, hsync and vsync reflect the counter position after exactly 3 clocks, with the same latency on all five outputs.
- Each buffer pixel is output for 2 consecutive clocks and on 2 consecutive lines.
- Colour is 0 on every blanking clock.
- Line period is 800 clocks; frame period is 420000 clocks.
- rst_n asserted mid-frame: all state clears asynchronously. After release, the frame restarts at (0,0) with a full pipeline refill of 3 clocks. No partial-line output.
- There is no write-port interaction. A concurrent write to the address being read returns whatever the buffer's read-during-write behaviour produces.

## Test plan
- Reset: hold rst_n low, then toggle it low asynchronously mid-cycle → hsync = vsync = 1, RGB = 0, rd_en = 0, rd_addr = 0 immediately. After release, rd_en = 1 with rd_addr = 0 one clock later.
- Horizontal timing: run 3 lines → hsync falls 659 clocks after release, stays low 96 clocks, period 800. RGB is nonzero only during 640-clock windows.
- Address mapping: sample rd_addr at counter positions → (h=2, v=1) gives 1; (0, 2) gives 320; (639, 479) gives 76799. rd_en = 0 and rd_addr = 0 at (640, 0) and (0, 480).
- Data alignment: the buffer model returns rd_data = rd_addr[11:0] registered → the output sequence on line 0 is 0,0,1,1,2,2,…. Line 1 repeats line 0; line 2 starts at 320 (12'h140).
- Vertical/frame: run 2 frames → vsync low for 1600 clocks starting at line 490 (+3 clocks). frame_end pulses exactly once every 420000 clocks. The second frame's first rd_addr is 0.
- Reset mid-frame: assert rst_n at (h=300, v=100) for 5 clocks → outputs return to reset values without a clock edge. After release, hsync first falls 659 clocks later and the address sequence restarts at 0.
